// File: rtl/vedic_seq_mul_ctrl.sv
// Sequential Vedic multiplier controller: one external 2x2 tile product per
// cycle, accumulated at digit weight 2*(i+j) over N*N steps.
module vedic_seq_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               tile_en,
  output logic [1:0]         tile_a,
  output logic [1:0]         tile_b,
  input  logic [3:0]         tile_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N  = WIDTH / 2;
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] part;
  // step counter k kept as its digit pair: i = k mod N, j = k div N
  logic [DW-1:0] i_q, i_d;
  logic [DW-1:0] j_q, j_d;
  logic last_step;

  assign last_step = (i_q == DW'(N - 1)) && (j_q == DW'(N - 1));
  assign product   = acc_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    i_d       = i_q;
    j_d       = j_q;
    part      = '0;
    in_ready  = 1'b0;
    tile_en   = 1'b0;
    tile_a    = 2'b00;
    tile_b    = 2'b00;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        tile_en = 1'b1;
        busy    = 1'b1;
        tile_a  = a_q[2*i_q +: 2];
        tile_b  = b_q[2*j_q +: 2];
        part    = PW'(tile_p) << (2 * (int'(i_q) + int'(j_q)));
        acc_d   = acc_q + part;
        if (i_q == DW'(N - 1)) begin
          i_d = '0;
          j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
        if (last_step) begin
          i_d     = '0;
          j_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

endmodule

// File: doc/vedic_seq_mul_ctrl.md
VEDIC_SEQ_MUL_CTRL -- requirements
Module: vedic_seq_mul_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and >= 4.
REQ-002 N = WIDTH/2 is the digit count; a digit is 2 bits. STEPS = N*N.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port in_valid, input, 1 bit: operands on in_a/in_b are valid.
REQ-006 Port in_ready, output, 1 bit: block can accept operands.
REQ-007 Port in_a, input, WIDTH bits: unsigned multiplicand.
REQ-008 Port in_b, input, WIDTH bits: unsigned multiplier.
REQ-009 Port tile_en, output, 1 bit: external 2x2 multiplier tile in use this cycle.
REQ-010 Port tile_a, output, 2 bits: digit of A driven to the tile.
REQ-011 Port tile_b, output, 2 bits: digit of B driven to the tile.
REQ-012 Port tile_p, input, 4 bits: combinational tile product, tile_a*tile_b, same cycle.
REQ-013 Port out_valid, output, 1 bit: product available.
REQ-014 Port out_ready, input, 1 bit: consumer accepts product.
REQ-015 Port product, output, 2*WIDTH bits: unsigned A*B.
REQ-016 Port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE: in_ready=1, tile_en=0, out_valid=0, busy=0.
REQ-019 IDLE with in_valid=1 SHALL, at the edge: latch a_reg=in_a, b_reg=in_b, clear acc and step counter k, and go to RUN.
REQ-020 In IDLE with in_valid=0, the block SHALL hold all state.
REQ-021 In RUN: in_ready=0, tile_en=1, i = k mod N, j = k div N.
REQ-022 In RUN: tile_a = a_reg[2i+1:2i] and tile_b = b_reg[2j+1:2j], combinational from k.
REQ-023 Each RUN cycle SHALL do acc <= acc + (zero-extended tile_p << 2*(i+j)) and k <= k+1.
REQ-024 acc width SHALL be 2*WIDTH; a correct design has no overflow, so no saturation and no wrap handling.
REQ-025 When k = STEPS-1, the final accumulate SHALL occur and the next state SHALL be DONE, with k cleared.
REQ-026 Exactly STEPS RUN cycles per operation; no early exit on zero operands.
REQ-027 In DONE: out_valid=1, product=acc, in_ready=0, tile_en=0.
REQ-028 product and out_valid SHALL be stable while out_ready=0 (back-pressure hold, unbounded).
REQ-029 DONE with out_ready=1 SHALL go to IDLE at the edge; out_valid drops next cycle.
REQ-030 Latency SHALL be STEPS+1 cycles from the accepting edge to out_valid high (17 for WIDTH=8).
REQ-031 Min initiation interval SHALL be STEPS+2 cycles (accept, STEPS RUN, one DONE cycle, IDLE re-accept).
REQ-032 in_valid/in_a/in_b SHALL be ignored outside IDLE; no operand is consumed while busy.
REQ-033 product SHALL retain the last result in IDLE until the next accept clears acc.
REQ-034 When out_ready is high before out_valid, the block SHALL take no action; the handshake completes only in DONE.
REQ-035 When tile_en=0, tile_a and tile_b SHALL be driven to 2'b00.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE with k=0, acc=0, a_reg=0 and b_reg=0 in any state, including mid-RUN and DONE.
REQ-037 After reset: in_ready=1, out_valid=0, busy=0, tile_en=0, product=0.
REQ-038 rst SHALL take priority over in_valid and out_ready in the same cycle; the in-flight operation is discarded with no output.
REQ-039 The first accept SHALL be possible on the first edge after rst deasserts.

Verification
REQ-040 WIDTH=8, a=255, b=255 with an ideal tile model and out_ready=1 -> out_valid in cycle 17 after accept, product=65025, out_valid high for 1 cycle.
REQ-041 a=0, b=173 -> product=0 after the full 17 cycles; tile_en high exactly 16 cycles.
REQ-042 a=3, b=2 with out_ready=0 for 10 cycles -> out_valid and product=6 held for all 10 cycles; in_ready=0 throughout; new in_valid ignored.
REQ-043 Back-to-back 200*100 then 17*15 with in_valid held -> products 20000 then 255; second accept 18 cycles after the first.
REQ-044 rst pulsed at RUN step 7 of 123*45 -> next cycle IDLE, in_ready=1, out_valid=0, product=0; a following 9*9 returns 81.
REQ-045 Random 10k unsigned pairs at WIDTH=8 and WIDTH=16 -> product equals the reference multiply; the tile digit sequence matches REQ-022.
